// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the alu_arbiter block: FSM states, ALU opcodes
// and bit positions inside the {overflow, cout, zero} flag vector.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_COUT = 1;
    localparam int FLAG_OVF  = 2;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the response
// consumer. The arbiter uses the slave view; the issue side uses master.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ*3-1:0]          req_op;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_W-1:0]               resp_id;
    logic [DATA_WIDTH-1:0]         resp_result;
    logic [2:0]                    resp_flags;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_flags
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU shared by the arbiter. Flags are {overflow, cout, zero};
// overflow/cout are only driven for add and sub, cout means "no borrow" on sub.
module alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             cout,
    output logic             zero
);
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Opcode decode
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        cout     = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum_s[WIDTH-1:0];
                cout     = sum_s[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff_s[WIDTH-1:0];
                cout     = diff_s[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LT:   result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Purely combinational round-robin pick: the first set request found when
// scanning upward from last_grant+1, wrapping modulo N.
module rr_picker #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);
    logic found_s;

    // Rotating priority scan; last_grant itself is checked last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % N;
            if (!found_s && req[idx]) begin
                found_s    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front-end sharing one ALU among NUM_REQ requesters (IDLE->EXEC->RESP).
// Optional ALU_ARB_PERF_EN adds saturating perf_ops / perf_stall counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]  perf_ops,
    output logic [15:0]  perf_stall
`endif
);
    arb_state_t            state_r;
    arb_state_t            state_nxt_s;
    logic [ID_W-1:0]       last_grant_r;
    logic [ID_W-1:0]       id_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    logic [2:0]            op_r;

    logic [NUM_REQ-1:0]    pick_onehot_s;
    logic [ID_W-1:0]       pick_idx_s;
    logic [NUM_REQ-1:0]    ready_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] a_sel_s;
    logic [DATA_WIDTH-1:0] b_sel_s;
    logic [2:0]            op_sel_s;

    logic [DATA_WIDTH-1:0] alu_result_s;
    logic                  alu_ovf_s;
    logic                  alu_cout_s;
    logic                  alu_zero_s;

    logic                  resp_valid_r;
    logic [ID_W-1:0]       resp_id_r;
    logic [DATA_WIDTH-1:0] resp_result_r;
    logic [2:0]            resp_flags_r;

    rr_picker #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_picker (
        .req        (bus.req_valid),
        .last_grant (last_grant_r),
        .grant      (pick_onehot_s),
        .grant_idx  (pick_idx_s)
    );

    alu #(
        .WIDTH (DATA_WIDTH)
    ) u_alu (
        .a        (a_r),
        .b        (b_r),
        .op       (op_r),
        .result   (alu_result_s),
        .overflow (alu_ovf_s),
        .cout     (alu_cout_s),
        .zero     (alu_zero_s)
    );

    // Ready only offered in IDLE and never while reset is held
    always_comb begin
        if (rst_n && (state_r == IDLE)) begin
            ready_s = pick_onehot_s;
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s = |(bus.req_valid & ready_s);

    // One-hot AND-OR mux of the granted requester's payload
    always_comb begin
        a_sel_s  = '0;
        b_sel_s  = '0;
        op_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_sel_s  = a_sel_s  | (bus.req_a[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{pick_onehot_s[i]}});
            b_sel_s  = b_sel_s  | (bus.req_b[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{pick_onehot_s[i]}});
            op_sel_s = op_sel_s | (bus.req_op[i*3 +: 3] & {3{pick_onehot_s[i]}});
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture on accept, result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r  <= ID_W'(NUM_REQ - 1);
            id_r          <= '0;
            a_r           <= '0;
            b_r           <= '0;
            op_r          <= 3'b000;
            resp_valid_r  <= 1'b0;
            resp_id_r     <= '0;
            resp_result_r <= '0;
            resp_flags_r  <= 3'b000;
        end else begin
            if (accept_s) begin
                a_r          <= a_sel_s;
                b_r          <= b_sel_s;
                op_r         <= op_sel_s;
                id_r         <= pick_idx_s;
                last_grant_r <= pick_idx_s;
            end
            if (state_r == EXEC) begin
                resp_valid_r            <= 1'b1;
                resp_id_r               <= id_r;
                resp_result_r           <= alu_result_s;
                resp_flags_r[FLAG_OVF]  <= alu_ovf_s;
                resp_flags_r[FLAG_COUT] <= alu_cout_s;
                resp_flags_r[FLAG_ZERO] <= alu_zero_s;
            end else if ((state_r == RESP) && bus.resp_ready) begin
                resp_valid_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = ready_s;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_id     = resp_id_r;
    assign bus.resp_result = resp_result_r;
    assign bus.resp_flags  = resp_flags_r;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf_ops_r;
    logic [15:0] perf_stall_r;

    // Saturating accept and backpressure counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_r   <= 16'h0000;
            perf_stall_r <= 16'h0000;
        end else begin
            if (accept_s && (perf_ops_r != 16'hFFFF)) begin
                perf_ops_r <= perf_ops_r + 16'h0001;
            end
            if ((state_r == RESP) && !bus.resp_ready && (perf_stall_r != 16'hFFFF)) begin
                perf_stall_r <= perf_stall_r + 16'h0001;
            end
        end
    end

    assign perf_ops   = perf_ops_r;
    assign perf_stall = perf_stall_r;
`endif

endmodule
